// File: rtl/pixel_write_buffer.sv
// ---------------------------------------------------------------------------
// pixel_write_buffer
//
// Sink end of the drawing controllers' plot interface. Each one-cycle plot
// strobe carries an (x, y, colour) pixel. Pixels outside the visible screen
// are clipped here. The rest are queued in a small FIFO. A drain FSM pops the
// queue, turns each pixel into a linear framebuffer address
// (y * SCREEN_W + x) and presents it on an arbitrated write port. The write
// is held until the arbiter grants it.
//
// Optional feature (macro PIXWR_CLIP_CNT_EN): adds the clip_cnt output, a
// saturating 8-bit count of pixels discarded by the clip check.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   plot       in   pixel strobe, one pixel per cycle high
//   x, y       in   pixel column / row, sampled with plot
//   colour     in   pixel colour, sampled with plot
//   ready      out  FIFO can accept a pixel this cycle
//   mem_addr   out  framebuffer write address
//   mem_data   out  framebuffer write data
//   mem_we     out  write request, high while a write is pending
//   mem_grant  in   arbiter accepts the pending write this cycle
//   idle       out  FIFO empty and no write in flight
//   drop       out  sticky: plot seen while ready was low
//   clip_cnt   out  (PIXWR_CLIP_CNT_EN only) saturating clipped-pixel count
// ---------------------------------------------------------------------------
module pixel_write_buffer #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int C_W      = 3,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              plot,
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    input  logic [C_W-1:0]    colour,
    output logic              ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [C_W-1:0]    mem_data,
    output logic              mem_we,
    input  logic              mem_grant,
    output logic              idle,
    output logic              drop
`ifdef PIXWR_CLIP_CNT_EN
    ,
    output logic [7:0]        clip_cnt
`endif
);

    localparam int E_W   = X_W + Y_W + C_W;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {
        IDLE,
        WRITE
    } state_t;

    state_t             state_q;
    logic [E_W-1:0]     fifoMem_q [DEPTH];
    logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               drop_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [C_W-1:0]     data_q;
    logic               we_q;

    logic               inBounds;
    logic               push;
    logic               pop;
    logic               notEmpty;
    logic [E_W-1:0]     head;
    logic [X_W-1:0]     headX;
    logic [Y_W-1:0]     headY;
    logic [C_W-1:0]     headC;
    logic [ADDR_W-1:0]  headAddr;

    // Handshake and status flags come straight from registered state, so
    // reset drives them to their idle values without waiting for a clock.
    assign ready    = (count_q != CNT_W'(DEPTH));
    assign notEmpty = (count_q != '0);
    assign idle     = !notEmpty && (state_q == IDLE);
    assign drop     = drop_q;
    assign mem_addr = addr_q;
    assign mem_data = data_q;
    assign mem_we   = we_q;

    // Clip check on the raw coordinates; widened so the compare is exact.
    assign inBounds = (int'(x) < SCREEN_W) && (int'(y) < SCREEN_H);
    assign push     = plot && ready && inBounds;

    // Pop in IDLE whenever data is queued; in WRITE only on the granted
    // cycle, so the next entry is loaded exactly as the current one commits.
    assign pop      = notEmpty && ((state_q == IDLE) || mem_grant);

    // Unpack the head entry and form its linear address at full width.
    assign head     = fifoMem_q[rdPtr_q];
    assign headX    = head[E_W-1 -: X_W];
    assign headY    = head[C_W +: Y_W];
    assign headC    = head[C_W-1:0];
    assign headAddr = ADDR_W'(headY) * ADDR_W'(SCREEN_W) + ADDR_W'(headX);

    // Next-state for the FIFO pointers and occupancy count. A push and a pop
    // in the same cycle leave the count unchanged.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (push) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset. Only the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= {x, y, colour};
        end
    end

    // FIFO control registers and the sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            if (plot && !ready) begin
                drop_q <= 1'b1;
            end
        end
    end

    // Drain FSM with registered write-port outputs. mem_we is high exactly
    // while in WRITE. Address and data only change on a pop, so they stay
    // stable through any number of ungranted cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (notEmpty) begin
                        addr_q  <= headAddr;
                        data_q  <= headC;
                        we_q    <= 1'b1;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    if (mem_grant) begin
                        if (notEmpty) begin
                            addr_q  <= headAddr;
                            data_q  <= headC;
                        end else begin
                            we_q    <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    we_q    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef PIXWR_CLIP_CNT_EN
    logic [7:0] clipCnt_q;

    // Saturating count of accepted-but-clipped pixels. It sticks at 255.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clipCnt_q <= '0;
        end else if (plot && ready && !inBounds && (clipCnt_q != 8'hFF)) begin
            clipCnt_q <= clipCnt_q + 8'd1;
        end
    end

    assign clip_cnt = clipCnt_q;
`endif

endmodule

// File: tb/tb_pixel_write_buffer.sv
// ---------------------------------------------------------------------------
// tb_pixel_write_buffer
//
// Directed scenarios followed by a randomized run. Every cycle's outputs are
// compared with a transaction-level reference model. The model is a queue of
// waiting pixels plus one in-flight pixel, and it expects a write to commit
// whenever the in-flight pixel sees a grant.
// ---------------------------------------------------------------------------
module tb_pixel_write_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        plot;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        ready;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_we;
    logic        mem_grant;
    logic        idle;
    logic        drop;
`ifdef PIXWR_CLIP_CNT_EN
    logic [7:0]  clip_cnt;
`endif

    pixel_write_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .plot      (plot),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .ready     (ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_we    (mem_we),
        .mem_grant (mem_grant),
        .idle      (idle),
        .drop      (drop)
`ifdef PIXWR_CLIP_CNT_EN
        ,
        .clip_cnt  (clip_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int px;
        int py;
        int pc;
    } pix_t;

    pix_t queueM[$];
    pix_t curM;
    bit   inflightM;
    bit   dropM;
    int   clipM;
    int   writesM;
    int   dutWrites;
    int   checks;
    int   errors;

    // Count committed writes as seen on the DUT port.
    always @(posedge clk) begin
        if (!reset && mem_we && mem_grant) begin
            dutWrites <= dutWrites + 1;
        end
    end

    task automatic modelReset();
        queueM.delete();
        inflightM = 1'b0;
        dropM     = 1'b0;
        clipM     = 0;
        curM      = '{0, 0, 0};
    endtask

    // Advance the model by one clock edge using the pre-edge state.
    task automatic modelStep();
        int  cnt;
        bit  commit;
        bit  doPop;
        bit  inB;
        cnt    = queueM.size();
        commit = inflightM && mem_grant;
        doPop  = (cnt != 0) && (!inflightM || mem_grant);
        inB    = (int'(x) < 160) && (int'(y) < 120);
        if (commit) begin
            writesM++;
            inflightM = 1'b0;
        end
        if (doPop) begin
            curM      = queueM.pop_front();
            inflightM = 1'b1;
        end
        if (plot && cnt == DEPTH) dropM = 1'b1;
        if (plot && cnt != DEPTH) begin
            if (inB) queueM.push_back('{int'(x), int'(y), int'(colour)});
            else if (clipM < 255) clipM++;
        end
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert (mem_we === inflightM) else begin
            errors++;
            $error("[TB] FAIL %s mem_we observed %b expected %b", tag, mem_we, inflightM);
        end
        checks++;
        assert (ready === (queueM.size() != DEPTH)) else begin
            errors++;
            $error("[TB] FAIL %s ready observed %b expected %b", tag, ready, queueM.size() != DEPTH);
        end
        checks++;
        assert (idle === (queueM.size() == 0 && !inflightM)) else begin
            errors++;
            $error("[TB] FAIL %s idle observed %b expected %b", tag, idle, queueM.size() == 0 && !inflightM);
        end
        checks++;
        assert (drop === dropM) else begin
            errors++;
            $error("[TB] FAIL %s drop observed %b expected %b", tag, drop, dropM);
        end
        if (inflightM) begin
            checks++;
            assert (mem_addr === 15'(curM.py * 160 + curM.px)) else begin
                errors++;
                $error("[TB] FAIL %s mem_addr observed %0d expected %0d", tag, mem_addr, curM.py * 160 + curM.px);
            end
            checks++;
            assert (mem_data === 3'(curM.pc)) else begin
                errors++;
                $error("[TB] FAIL %s mem_data observed %0d expected %0d", tag, mem_data, curM.pc);
            end
        end
`ifdef PIXWR_CLIP_CNT_EN
        checks++;
        assert (clip_cnt === 8'(clipM)) else begin
            errors++;
            $error("[TB] FAIL %s clip_cnt observed %0d expected %0d", tag, clip_cnt, clipM);
        end
`endif
    endtask

    // Drive one cycle of inputs, clock it, then check #1 after the edge.
    task automatic applyStimulus(input bit p, input int px, input int py,
                                 input int pc, input bit g, input string tag);
        plot      = p;
        x         = 8'(px);
        y         = 7'(py);
        colour    = 3'(pc);
        mem_grant = g;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput(tag);
    endtask

    task automatic checkValue(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        logic [14:0] heldAddr;
        int          wrBase;
        checks    = 0;
        errors    = 0;
        writesM   = 0;
        dutWrites = 0;
        modelReset();
        reset     = 1'b1;
        plot      = 1'b0;
        x         = '0;
        y         = '0;
        colour    = '0;
        mem_grant = 1'b0;
        #3;
        checkOutput("reset");
        checkValue("reset_addr", int'(mem_addr), 0);
        checkValue("reset_data", int'(mem_data), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single pixel: one write to 325 with colour 3, committed at N+2.
        wrBase = dutWrites;
        applyStimulus(1, 5, 2, 3, 1, "single_plot");
        applyStimulus(0, 0, 0, 0, 1, "single_we");
        checkValue("single_addr", int'(mem_addr), 325);
        checkValue("single_we_hi", int'(mem_we), 1);
        applyStimulus(0, 0, 0, 0, 1, "single_done");
        checkValue("single_idle", int'(idle), 1);
        applyStimulus(0, 0, 0, 0, 1, "single_settle");
        checkValue("single_count", dutWrites - wrBase, 1);

        // Burst along the bottom row, grant held high.
        for (int i = 0; i < 4; i++) applyStimulus(1, i, 119, i + 1, 1, "burst");
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1, "burst_drain");

        // Backpressure: grant low, overfill, then release.
        for (int i = 0; i < 6; i++) applyStimulus(1, 10 + i, 3, i, 0, "bp_fill");
        checkValue("bp_drop", int'(drop), 1);
        checkValue("bp_ready", int'(ready), 0);
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 0, 1, "bp_drain");
        checkValue("bp_idle", int'(idle), 1);

        // Clipping at the screen edges.
        applyStimulus(1, 160, 0, 1, 1, "clip_x");
        applyStimulus(1, 0, 120, 2, 1, "clip_y");
        applyStimulus(0, 0, 0, 0, 1, "clip_after");
        checkValue("clip_no_we", int'(mem_we), 0);

        // Stall hold: address must not move while grant is low.
        applyStimulus(1, 77, 50, 6, 0, "stall_plot");
        applyStimulus(0, 0, 0, 0, 0, "stall_load");
        heldAddr = mem_addr;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, "stall_hold");
            checkValue("stall_addr", int'(mem_addr), int'(heldAddr));
        end
        applyStimulus(0, 0, 0, 0, 1, "stall_commit");
        applyStimulus(0, 0, 0, 0, 1, "stall_idle");

        // Reset mid-burst with one write in flight and two entries queued.
        applyStimulus(1, 1, 1, 1, 0, "rst_a");
        applyStimulus(1, 2, 1, 2, 0, "rst_b");
        applyStimulus(1, 3, 1, 3, 0, "rst_c");
        checkValue("rst_pre_we", int'(mem_we), 1);
        wrBase = dutWrites;
        #2 reset = 1'b1;
        modelReset();
        #1;
        checkOutput("rst_async");
        mem_grant = 1'b1;
        plot      = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1, "rst_after");
        checkValue("rst_no_writes", dutWrites - wrBase, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 170),
                          $urandom_range(0, 125), $urandom_range(0, 7),
                          $urandom_range(0, 9) < 6, "random");
        end
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 1, "random_drain");
        checkValue("total_writes", dutWrites, writesM);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
